bin2bcd_seq: RTL and testbench

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bin2bcd_seq.sv | 83 ++++++++
 tb/tb_bin2bcd_seq.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter; define BIN2BCD_BLANK_EN for leading-zero blank flags
module bin2bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     blank_out
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t              state_q, state_d;
  logic [WIDTH-1:0]    op_q, op_d;
  logic [4*DIGITS-1:0] scr_q, scr_d, adj, bcd_q, bcd_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                accept, shifting, load;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
    end
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = start ? SHIFT : IDLE;
      SHIFT:   state_d = (cnt_q == '0) ? DONE : SHIFT;
      DONE:    state_d = start ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    accept   = start && (state_q != SHIFT);
    shifting = (state_q == SHIFT) && (cnt_q != '0);
    load     = (state_q == SHIFT) && (cnt_q == '0);
    adj      = '0;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i +: 4] = (scr_q[4*i +: 4] >= 4'd5) ? scr_q[4*i +: 4] + 4'd3 : scr_q[4*i +: 4];
    op_d  = accept ? bin_in : shifting ? op_q << 1 : op_q;
    scr_d = accept ? '0 : shifting ? (adj << 1) | {{(4*DIGITS-1){1'b0}}, op_q[WIDTH-1]} : scr_q;
    cnt_d = accept ? CW'(WIDTH) : shifting ? cnt_q - CW'(1) : cnt_q;
    bcd_d = load ? scr_q : bcd_q;
  end
  always_comb begin
    busy    = shifting;
    done    = (state_q == DONE);
    bcd_out = bcd_q;
  end
`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d;
  logic              zero_run;
  always_ff @(posedge clk) begin
    if (!rst_n) blank_q <= '0;
    else        blank_q <= blank_d;
  end
  always_comb begin
    blank_d  = '0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run   = zero_run && (scr_q[4*i +: 4] == 4'd0);
      blank_d[i] = zero_run;
    end
    blank_d = load ? blank_d : blank_q;
  end
  assign blank_out = blank_q;
`else
  assign blank_out = '0;
`endif
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed-vector bench for bin2bcd_seq
module tb_bin2bcd_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] bin_in = '0;
  logic        busy, done;
  logic [19:0] bcd_out;
  logic [4:0]  blank_out;
  int          n_vec = 0;
  int          n_err = 0;
  int          lat, bcnt, dcnt;
  bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .bcd_out(bcd_out), .blank_out(blank_out)
  );
  always #5 clk = ~clk;
  function automatic logic [4:0] blk(input logic [4:0] v);
`ifdef BIN2BCD_BLANK_EN
    return v;
`else
    return v & 5'b0;
`endif
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wait_done(output int l, output int b);
    l = -1;
    b = 0;
    for (int n = 0; n < 40; n++) begin
      if (busy) b++;
      if (done) begin
        l = n;
        break;
      end
      @(negedge clk);
    end
  endtask
  task automatic conv(input logic [15:0] v, output int l, output int b);
    @(negedge clk);
    start = 1'b1;
    bin_in = v;
    @(negedge clk);
    start = 1'b0;
    wait_done(l, b);
  endtask
  task automatic count_done(input int cycles, output int c);
    c = 0;
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      if (done) c++;
    end
  endtask
  initial begin
    // reset with start held high: must be ignored
    @(negedge clk);
    start = 1'b1;
    bin_in = 16'd77;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bcd", bcd_out, 0);
    chk("rst_blank", blank_out, 0);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_idle_busy", busy, 0);
    conv(16'd0, lat, bcnt);
    chk("zero_lat", lat, 17);
    chk("zero_bcd", bcd_out, 20'h00000);
    chk("zero_blank", blank_out, blk(5'b11110));
    conv(16'd65535, lat, bcnt);
    chk("max_lat", lat, 17);
    chk("max_busy_cycles", bcnt, 16);
    chk("max_bcd", bcd_out, 20'h65535);
    chk("max_blank", blank_out, 5'b00000);
    @(negedge clk);
    chk("max_done_one_cycle", done, 0);
    chk("max_bcd_hold", bcd_out, 20'h65535);
    // 1234 with a stray start of 9 mid-conversion
    start = 1'b1;
    bin_in = 16'd1234;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("ign_busy", busy, 1);
    start = 1'b1;
    bin_in = 16'd9;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bcnt);
    chk("ign_lat", lat, 12);
    chk("ign_bcd", bcd_out, 20'h01234);
    chk("ign_blank", blank_out, blk(5'b10000));
    count_done(25, dcnt);
    chk("ign_single_done", dcnt, 0);
    chk("ign_bcd_hold", bcd_out, 20'h01234);
    // reset during SHIFT cycle 8 of 500
    start = 1'b1;
    bin_in = 16'd500;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_bcd", bcd_out, 0);
    rst_n = 1'b1;
    count_done(25, dcnt);
    chk("abort_no_done", dcnt, 0);
    conv(16'd500, lat, bcnt);
    chk("redo_lat", lat, 17);
    chk("redo_bcd", bcd_out, 20'h00500);
    chk("redo_blank", blank_out, blk(5'b11000));
    // back-to-back: start in the DONE cycle
    conv(16'd42, lat, bcnt);
    chk("b2b1_lat", lat, 17);
    chk("b2b1_bcd", bcd_out, 20'h00042);
    chk("b2b1_blank", blank_out, blk(5'b11100));
    start = 1'b1;
    bin_in = 16'd7;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy_next", busy, 1);
    chk("b2b_done_low", done, 0);
    chk("b2b_bcd_hold", bcd_out, 20'h00042);
    wait_done(lat, bcnt);
    chk("b2b2_lat", lat, 17);
    chk("b2b2_bcd", bcd_out, 20'h00007);
    chk("b2b2_blank", blank_out, blk(5'b11110));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
